// File: rtl/nanosoc_pad_mux_ctrl.sv
// ----------------------------------------------------------------------------
// nanosoc_pad_mux_ctrl
//
// Chip-level pad multiplexer and test-mode controller. Sits between the pad
// ring and the nanosoc_system GPIO. It lends the low 2*TIO_WIDTH pins of
// GPIO port 0 (the "borrowed" pins) to a scan, BIST or UART test function.
// All other pins stay GPIO in every mode.
//
// Mode changes go through a DRAIN phase. During DRAIN every borrowed pin is
// tri-stated for DRAIN_CYCLES cycles, so no pad is ever driven by two
// functions in consecutive cycles.
//
// Parameters:
//   NUM_PORTS    number of 16-bit GPIO ports (P = 16*NUM_PORTS pins)
//   TIO_WIDTH    pins per test direction, 2*TIO_WIDTH <= 16
//   SYNC_STAGES  synchroniser depth on mode pins and pad inputs, 0..3
//                (0 = combinational)
//   DRAIN_CYCLES tri-state cycles per mode change, 1..255
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   scan_mode_i          scan mode request pin (highest priority)
//   bist_mode_i          BIST mode request pin
//   alt_mode_i           UART mode request pin (lowest priority)
//   pad_i                level-shifted pad inputs
//   pad_o, pad_e, pad_z  pad drive value, output enable, inverted enable
//   gpio_in_o            synchronised pad inputs to the system
//   gpio_out_i           system GPIO output values
//   gpio_outen_i         system GPIO output enables
//   scan_in_o/scan_out_i scan chain data to/from the core
//   bist_in_o/bist_out_i BIST control to / status from the core
//   uart_rxd_o/uart_txd_i UART receive to / transmit from the core
//   mode_o               current mode: 0 FUNC, 1 SCAN, 2 BIST, 3 UART
//   switching_o          high while in DRAIN
// ----------------------------------------------------------------------------

module nanosoc_pad_mux_ctrl #(
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned TIO_WIDTH    = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    scan_mode_i,
    input  logic                    bist_mode_i,
    input  logic                    alt_mode_i,

    input  logic [16*NUM_PORTS-1:0] pad_i,
    output logic [16*NUM_PORTS-1:0] pad_o,
    output logic [16*NUM_PORTS-1:0] pad_e,
    output logic [16*NUM_PORTS-1:0] pad_z,

    output logic [16*NUM_PORTS-1:0] gpio_in_o,
    input  logic [16*NUM_PORTS-1:0] gpio_out_i,
    input  logic [16*NUM_PORTS-1:0] gpio_outen_i,

    output logic [TIO_WIDTH-1:0]    scan_in_o,
    input  logic [TIO_WIDTH-1:0]    scan_out_i,
    output logic [TIO_WIDTH-1:0]    bist_in_o,
    input  logic [TIO_WIDTH-1:0]    bist_out_i,
    output logic                    uart_rxd_o,
    input  logic                    uart_txd_i,

    output logic [1:0]              mode_o,
    output logic                    switching_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned Pins   = 16 * NUM_PORTS;
    localparam int unsigned Borrow = 2 * TIO_WIDTH;

    localparam logic [1:0] ModeFunc = 2'd0;
    localparam logic [1:0] ModeScan = 2'd1;
    localparam logic [1:0] ModeBist = 2'd2;
    localparam logic [1:0] ModeUart = 2'd3;

    localparam logic StActive = 1'b0;
    localparam logic StDrain  = 1'b1;

    // Counter runs DRAIN_CYCLES-1 down to 0, giving DRAIN_CYCLES drain cycles.
    localparam logic [7:0] DrainLoad = 8'(DRAIN_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Input synchronisers (mode pins and pad inputs)
    // ------------------------------------------------------------------------
    logic [2:0]      mode_pins;
    logic [2:0]      mode_sync;
    logic [Pins-1:0] pad_sync;

    assign mode_pins = {scan_mode_i, bist_mode_i, alt_mode_i};

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign mode_sync = mode_pins;
            assign pad_sync  = pad_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][2:0]      mode_q;
            logic [SYNC_STAGES-1:0][Pins-1:0] pad_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    mode_q <= '0;
                    pad_q  <= '0;
                end else begin
                    mode_q[0] <= mode_pins;
                    pad_q[0]  <= pad_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        mode_q[i] <= mode_q[i-1];
                        pad_q[i]  <= pad_q[i-1];
                    end
                end
            end

            assign mode_sync = mode_q[SYNC_STAGES-1];
            assign pad_sync  = pad_q[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Requested mode: scan > bist > alt > FUNC
    // ------------------------------------------------------------------------
    logic [1:0] req;

    always_comb begin
        if (mode_sync[2]) begin
            req = ModeScan;
        end else if (mode_sync[1]) begin
            req = ModeBist;
        end else if (mode_sync[0]) begin
            req = ModeUart;
        end else begin
            req = ModeFunc;
        end
    end

    // ------------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------------
    logic       state_q, state_d;
    logic [1:0] cur_q, cur_d;
    logic [1:0] tgt_q, tgt_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        case (state_q)
            StActive: begin
                if (req != cur_q) begin
                    state_d = StDrain;
                    tgt_d   = req;
                    cnt_d   = DrainLoad;
                end
            end
            StDrain: begin
                // A changed request restarts the full drain; the old target
                // is never committed, even if its drain was nearly done.
                if (req != tgt_q) begin
                    tgt_d = req;
                    cnt_d = DrainLoad;
                end else if (cnt_q == 8'd0) begin
                    // May rewrite cur with its own value if req came back.
                    cur_d   = tgt_q;
                    state_d = StActive;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StActive;
            cur_q   <= ModeFunc;
            tgt_q   <= ModeFunc;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mode_o      = cur_q;
    assign switching_o = (state_q == StDrain);

    // ------------------------------------------------------------------------
    // Pad ownership and core-side test signals
    // ------------------------------------------------------------------------
    always_comb begin
        // Everything is plain GPIO unless a test function owns it.
        pad_o      = gpio_out_i;
        pad_e      = gpio_outen_i;
        scan_in_o  = '0;
        bist_in_o  = '0;
        uart_rxd_o = 1'b1;

        if (state_q == StDrain) begin
            pad_o[Borrow-1:0] = '0;
            pad_e[Borrow-1:0] = '0;
        end else begin
            case (cur_q)
                ModeScan: begin
                    pad_o[TIO_WIDTH-1:0]      = '0;
                    pad_e[TIO_WIDTH-1:0]      = '0;
                    pad_o[Borrow-1:TIO_WIDTH] = scan_out_i;
                    pad_e[Borrow-1:TIO_WIDTH] = '1;
                    // Raw pad value: scan shifting must not see sync latency.
                    scan_in_o                 = pad_i[TIO_WIDTH-1:0];
                end
                ModeBist: begin
                    pad_o[TIO_WIDTH-1:0]      = '0;
                    pad_e[TIO_WIDTH-1:0]      = '0;
                    pad_o[Borrow-1:TIO_WIDTH] = bist_out_i;
                    pad_e[Borrow-1:TIO_WIDTH] = '1;
                    bist_in_o                 = pad_i[TIO_WIDTH-1:0];
                end
                ModeUart: begin
                    pad_o[Borrow-1:0] = '0;
                    pad_e[Borrow-1:0] = '0;
                    pad_o[1]          = uart_txd_i;
                    pad_e[1]          = 1'b1;
                    uart_rxd_o        = pad_i[0];
                end
                default: begin
                    // FUNC: straight-through defaults above.
                end
            endcase
        end
    end

    assign pad_z = ~pad_e;

    // ------------------------------------------------------------------------
    // System-side inputs: borrowed pins read 0 while lent out or draining
    // ------------------------------------------------------------------------
    logic [Pins-1:0] in_mask;

    always_comb begin
        in_mask = '1;
        if ((state_q == StDrain) || (cur_q != ModeFunc)) begin
            in_mask[Borrow-1:0] = '0;
        end
    end

    assign gpio_in_o = pad_sync & in_mask;

endmodule
